// File: rtl/vga_ctrl_if.sv
// Pixel-side bundle between the VGA timing controller and the picture stage / DAC.
// The controller is the master: it issues pixel requests and drives sync and colour.
interface vga_ctrl_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [15:0] rgb;
    logic        frame_start;

    modport master (
        input  pix_data,
        output pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
    );
endinterface

// File: rtl/vga_ctrl.sv
// VGA timing generator: horizontal/vertical beam counters, sync decode, pixel
// requests issued one clock ahead of the active area, and a frame-start pulse.
module vga_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 40,
    parameter int H_LEFT   = 8,
    parameter int H_VALID  = 640,
    parameter int H_RIGHT  = 8,
    parameter int H_FRONT  = 8,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 25,
    parameter int V_TOP    = 8,
    parameter int V_VALID  = 480,
    parameter int V_BOTTOM = 8,
    parameter int V_FRONT  = 2,
    parameter int V_TOTAL  = 525
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    vga_ctrl_if.master vga
);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] HA_START  = 10'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [9:0] HA_END    = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID);
    localparam logic [9:0] VA_START  = 10'(V_SYNC + V_BACK + V_TOP);
    localparam logic [9:0] VA_END    = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);
    // The picture stage has one clock of latency, so requests lead the active area by one.
    localparam logic [9:0] REQ_START = 10'(H_SYNC + H_BACK + H_LEFT - 1);
    localparam logic [9:0] REQ_END   = 10'(H_SYNC + H_BACK + H_LEFT + H_VALID - 1);

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       frame_start_q;
    logic       line_end;
    logic       h_active;
    logic       v_active;
    logic       pix_data_req;

    assign line_end = (cnt_h == H_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h         <= '0;
            cnt_v         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= (cnt_h == '0) && (cnt_v == '0);
            if (line_end) begin
                cnt_h <= '0;
                cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
            end else begin
                cnt_h <= cnt_h + 10'd1;
            end
        end
    end

    assign h_active     = (cnt_h >= HA_START) && (cnt_h < HA_END);
    assign v_active     = (cnt_v >= VA_START) && (cnt_v < VA_END);
    assign pix_data_req = (cnt_h >= REQ_START) && (cnt_h < REQ_END) && v_active;

    assign vga.hsync       = (cnt_h < H_SYNC_W);
    assign vga.vsync       = (cnt_v < V_SYNC_W);
    assign vga.rgb_valid   = h_active && v_active;
    assign vga.pix_x       = pix_data_req ? (cnt_h - REQ_START) : 10'h3FF;
    assign vga.pix_y       = pix_data_req ? (cnt_v - VA_START) : 10'h3FF;
    assign vga.rgb         = vga.rgb_valid ? vga.pix_data : 16'h0000;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: a reduced-timing instance for full-frame checks and a
// default-timing instance for the first lines of the 640x480 mode.
module tb_vga_ctrl;

    logic vga_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 vga_clk = ~vga_clk;

    // Reduced timing: 30 clocks per line, 16 lines per frame, 480 clocks per frame.
    // Request columns 8..23, active columns 9..24, active lines 5..12.
    vga_ctrl_if s_if ();
    vga_ctrl_if b_if ();

    vga_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_LEFT(2), .H_VALID(16), .H_RIGHT(2), .H_FRONT(3), .H_TOTAL(30),
        .V_SYNC(2), .V_BACK(2), .V_TOP(1), .V_VALID(8), .V_BOTTOM(1), .V_FRONT(2), .V_TOTAL(16)
    ) u_dut_small (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .vga      (s_if.master)
    );

    vga_ctrl u_dut_def (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .vga      (b_if.master)
    );

    // Picture stage: registers a colour derived from the request coordinates.
    logic [15:0] pic_q;
    always_ff @(posedge vga_clk) pic_q <= {s_if.pix_x[5:0], s_if.pix_y};
    assign s_if.pix_data = pic_q;
    assign b_if.pix_data = 16'hA5A5;

    int t     = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sb[$];

    task automatic tick();
        @(posedge vga_clk);
        if (sys_rst_n) t++;
        @(negedge vga_clk);
    endtask

    task automatic release_reset();
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        t = 0;
        sb.delete();
    endtask

    task automatic goto(input int h, input int v);
        int n = 0;
        while ((((t % 30) != h) || (((t / 30) % 16) != v)) && n < 500) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 500) begin
            n_bad++;
            $display("FAIL goto(%0d,%0d) not reached got_t=%0d", h, v, t);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        n_cmp += 7;
        if (s_if.hsync !== 1'b1)       begin n_bad++; $display("FAIL rst_hsync got=%b exp=1", s_if.hsync); end
        if (s_if.vsync !== 1'b1)       begin n_bad++; $display("FAIL rst_vsync got=%b exp=1", s_if.vsync); end
        if (s_if.rgb_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_rgb_valid got=%b exp=0", s_if.rgb_valid); end
        if (s_if.pix_x !== 10'h3FF)    begin n_bad++; $display("FAIL rst_pix_x got=%h exp=3ff", s_if.pix_x); end
        if (s_if.pix_y !== 10'h3FF)    begin n_bad++; $display("FAIL rst_pix_y got=%h exp=3ff", s_if.pix_y); end
        if (s_if.rgb !== 16'h0000)     begin n_bad++; $display("FAIL rst_rgb got=%h exp=0000", s_if.rgb); end
        if (s_if.frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start got=%b exp=0", s_if.frame_start); end
        n_cmp += 2;
        if (b_if.rgb !== 16'h0000)     begin n_bad++; $display("FAIL rst_def_rgb got=%h exp=0000", b_if.rgb); end
        if (b_if.pix_x !== 10'h3FF)    begin n_bad++; $display("FAIL rst_def_pix_x got=%h exp=3ff", b_if.pix_x); end
    endtask

    // Default 640x480 timing over the first three lines (all outside the active area).
    task automatic test_default_timing();
        int hs_cnt = 0;
        int vs_cnt = 0;
        for (int i = 0; i < 2400; i++) begin
            logic e_hs, e_vs, e_fs;
            e_hs = (t % 800) < 96;
            e_vs = (t / 800) < 2;
            e_fs = (t == 1);
            if (b_if.hsync === 1'b1) hs_cnt++;
            if (b_if.vsync === 1'b1) vs_cnt++;
            n_cmp += 4;
            if (b_if.hsync !== e_hs) begin n_bad++; $display("FAIL def_hsync t=%0d got=%b exp=%b", t, b_if.hsync, e_hs); end
            if (b_if.vsync !== e_vs) begin n_bad++; $display("FAIL def_vsync t=%0d got=%b exp=%b", t, b_if.vsync, e_vs); end
            if (b_if.frame_start !== e_fs) begin n_bad++; $display("FAIL def_frame_start t=%0d got=%b exp=%b", t, b_if.frame_start, e_fs); end
            if (b_if.rgb_valid !== 1'b0 || b_if.rgb !== 16'h0000 || b_if.pix_x !== 10'h3FF) begin
                n_bad++;
                $display("FAIL def_idle t=%0d got rv=%b rgb=%h px=%h exp rv=0 rgb=0000 px=3ff", t, b_if.rgb_valid, b_if.rgb, b_if.pix_x);
            end
            tick();
        end
        n_cmp += 2;
        if (hs_cnt != 288)  begin n_bad++; $display("FAIL def_hsync_count got=%0d exp=288", hs_cnt); end
        if (vs_cnt != 1600) begin n_bad++; $display("FAIL def_vsync_count got=%0d exp=1600", vs_cnt); end
    endtask

    // Two full frames on the reduced instance, starting right after reset release.
    task automatic test_frames();
        int hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, req_cnt = 0, rgb_ok = 0;
        for (int i = 0; i < 960; i++) begin
            int h, v;
            logic e_hs, e_vs, e_rv, e_req, e_fs;
            logic [9:0] e_px, e_py;
            h = t % 30;
            v = (t / 30) % 16;
            e_hs  = h < 4;
            e_vs  = v < 2;
            e_rv  = (h >= 9) && (h < 25) && (v >= 5) && (v < 13);
            e_req = (h >= 8) && (h < 24) && (v >= 5) && (v < 13);
            e_fs  = (t >= 1) && (((t - 1) % 480) == 0);
            e_px  = e_req ? 10'(h - 8) : 10'h3FF;
            e_py  = e_req ? 10'(v - 5) : 10'h3FF;
            if (s_if.hsync === 1'b1) hs_cnt++;
            if (s_if.vsync === 1'b1) vs_cnt++;
            if (s_if.frame_start === 1'b1) fs_cnt++;
            if (s_if.pix_x !== 10'h3FF) req_cnt++;
            n_cmp += 6;
            if (s_if.hsync !== e_hs)       begin n_bad++; $display("FAIL hsync t=%0d got=%b exp=%b", t, s_if.hsync, e_hs); end
            if (s_if.vsync !== e_vs)       begin n_bad++; $display("FAIL vsync t=%0d got=%b exp=%b", t, s_if.vsync, e_vs); end
            if (s_if.rgb_valid !== e_rv)   begin n_bad++; $display("FAIL rgb_valid t=%0d got=%b exp=%b", t, s_if.rgb_valid, e_rv); end
            if (s_if.frame_start !== e_fs) begin n_bad++; $display("FAIL frame_start t=%0d got=%b exp=%b", t, s_if.frame_start, e_fs); end
            if (s_if.pix_x !== e_px)       begin n_bad++; $display("FAIL pix_x t=%0d got=%h exp=%h", t, s_if.pix_x, e_px); end
            if (s_if.pix_y !== e_py)       begin n_bad++; $display("FAIL pix_y t=%0d got=%h exp=%h", t, s_if.pix_y, e_py); end
            n_cmp++;
            if (s_if.rgb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rgb_sb_empty t=%0d got=%h exp=queued_value", t, s_if.rgb);
                end else begin
                    logic [15:0] e_rgb;
                    e_rgb = sb.pop_front();
                    if (s_if.rgb !== e_rgb) begin
                        n_bad++;
                        $display("FAIL rgb t=%0d got=%h exp=%h", t, s_if.rgb, e_rgb);
                    end else begin
                        rgb_ok++;
                    end
                end
            end else if (s_if.rgb !== 16'h0000) begin
                n_bad++;
                $display("FAIL rgb_idle t=%0d got=%h exp=0000", t, s_if.rgb);
            end
            if (e_req) sb.push_back({e_px[5:0], e_py});
            tick();
        end
        n_cmp += 6;
        if (hs_cnt != 128)   begin n_bad++; $display("FAIL hsync_count got=%0d exp=128", hs_cnt); end
        if (vs_cnt != 120)   begin n_bad++; $display("FAIL vsync_count got=%0d exp=120", vs_cnt); end
        if (fs_cnt != 2)     begin n_bad++; $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); end
        if (req_cnt != 256)  begin n_bad++; $display("FAIL request_count got=%0d exp=256", req_cnt); end
        if (rgb_ok != 256)   begin n_bad++; $display("FAIL rgb_match_count got=%0d exp=256", rgb_ok); end
        if (sb.size() != 0)  begin n_bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_request_window();
        goto(8, 5);
        n_cmp += 3;
        if (s_if.pix_x !== 10'd0)    begin n_bad++; $display("FAIL win_h8_pix_x got=%h exp=000", s_if.pix_x); end
        if (s_if.pix_y !== 10'd0)    begin n_bad++; $display("FAIL win_h8_pix_y got=%h exp=000", s_if.pix_y); end
        if (s_if.rgb_valid !== 1'b0) begin n_bad++; $display("FAIL win_h8_rgb_valid got=%b exp=0", s_if.rgb_valid); end
        goto(9, 5);
        n_cmp += 2;
        if (s_if.rgb_valid !== 1'b1) begin n_bad++; $display("FAIL win_h9_rgb_valid got=%b exp=1", s_if.rgb_valid); end
        if (s_if.pix_x !== 10'd1)    begin n_bad++; $display("FAIL win_h9_pix_x got=%h exp=001", s_if.pix_x); end
        goto(23, 5);
        n_cmp++;
        if (s_if.pix_x !== 10'd15)   begin n_bad++; $display("FAIL win_h23_pix_x got=%h exp=00f", s_if.pix_x); end
        goto(24, 5);
        n_cmp += 2;
        if (s_if.pix_x !== 10'h3FF)  begin n_bad++; $display("FAIL win_h24_pix_x got=%h exp=3ff", s_if.pix_x); end
        if (s_if.rgb_valid !== 1'b1) begin n_bad++; $display("FAIL win_h24_rgb_valid got=%b exp=1", s_if.rgb_valid); end
        goto(25, 5);
        n_cmp++;
        if (s_if.rgb_valid !== 1'b0) begin n_bad++; $display("FAIL win_h25_rgb_valid got=%b exp=0", s_if.rgb_valid); end
    endtask

    task automatic test_vertical_edges();
        int rows[3] = '{4, 12, 13};
        int exp_n[3] = '{0, 16, 16};
        for (int r = 0; r < 3; r++) begin
            int reqs = 0, valids = 0, y_ok = 0;
            goto(0, rows[r]);
            for (int i = 0; i < 30; i++) begin
                if (s_if.pix_x !== 10'h3FF) reqs++;
                if (s_if.pix_y === 10'd7) y_ok++;
                if (s_if.rgb_valid === 1'b1) valids++;
                tick();
            end
            if (r == 2) exp_n[r] = 0;
            n_cmp += 3;
            if (reqs != exp_n[r])   begin n_bad++; $display("FAIL vedge_reqs row=%0d got=%0d exp=%0d", rows[r], reqs, exp_n[r]); end
            if (valids != exp_n[r]) begin n_bad++; $display("FAIL vedge_valid row=%0d got=%0d exp=%0d", rows[r], valids, exp_n[r]); end
            if (y_ok != exp_n[r])   begin n_bad++; $display("FAIL vedge_pix_y7 row=%0d got=%0d exp=%0d", rows[r], y_ok, exp_n[r]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        goto(15, 7);
        #2 sys_rst_n = 1'b0;
        #1;
        n_cmp += 6;
        if (s_if.hsync !== 1'b1)       begin n_bad++; $display("FAIL mid_rst_hsync got=%b exp=1", s_if.hsync); end
        if (s_if.vsync !== 1'b1)       begin n_bad++; $display("FAIL mid_rst_vsync got=%b exp=1", s_if.vsync); end
        if (s_if.rgb_valid !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_rgb_valid got=%b exp=0", s_if.rgb_valid); end
        if (s_if.pix_x !== 10'h3FF)    begin n_bad++; $display("FAIL mid_rst_pix_x got=%h exp=3ff", s_if.pix_x); end
        if (s_if.pix_y !== 10'h3FF)    begin n_bad++; $display("FAIL mid_rst_pix_y got=%h exp=3ff", s_if.pix_y); end
        if (s_if.rgb !== 16'h0000)     begin n_bad++; $display("FAIL mid_rst_rgb got=%h exp=0000", s_if.rgb); end
        repeat (3) @(posedge vga_clk);
        release_reset();
        test_frames();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        release_reset();
        test_default_timing();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge vga_clk);
        release_reset();
        test_frames();
        test_request_window();
        test_vertical_edges();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
